// File: rtl/jpl_foc_clarke_mc_if.sv
// Request/result bundle for jpl_foc_clarke_mc: frame request lanes in, transformed lanes and status out.
interface jpl_foc_clarke_mc_if #(
   parameter int B    = 12,
   parameter int N_CH = 2
);
   logic              i_start;
   logic              i_mode;
   logic [N_CH*B-1:0] i_x;
   logic [N_CH*B-1:0] i_y;
   logic              o_busy;
   logic              o_done;
   logic [N_CH*B-1:0] o_p;
   logic [N_CH*B-1:0] o_q;
   logic [N_CH-1:0]   o_sat;
   logic              o_start_err;

   modport master (
      output i_start, i_mode, i_x, i_y,
      input  o_busy, o_done, o_p, o_q, o_sat, o_start_err
   );

   modport slave (
      input  i_start, i_mode, i_x, i_y,
      output o_busy, o_done, o_p, o_q, o_sat, o_start_err
   );
endinterface

// File: rtl/jpl_foc_clarke_mc.sv
// Multi-channel Clarke / inverse-Clarke transform: one start captures N_CH lane pairs, which are
// streamed through a single shared multiplier (2-stage pipeline) and published together on o_done.
module jpl_foc_clarke_mc #(
   parameter int B    = 12,
   parameter int N_CH = 2,
   parameter int K    = 15
) (
   input  logic               i_clk,
   input  logic               i_rst,
   jpl_foc_clarke_mc_if.slave bus
);

   localparam int  KW      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int  W       = B + K + 4;
   localparam real SQRT3   = 1.7320508075688772;
   localparam int  C_FWD_I = $rtoi(real'(64'd1 << K) / SQRT3 + 0.5);
   localparam int  C_INV_I = $rtoi(real'(64'd1 << K) * SQRT3 / 2.0 + 0.5);
   localparam logic signed [K+1:0] C_FWD = C_FWD_I[K+1:0];
   localparam logic signed [K+1:0] C_INV = C_INV_I[K+1:0];
   localparam logic signed [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
   localparam logic signed [W-1:0] HALF  = ONE <<< (K - 1);
   localparam logic signed [W-1:0] Q_MAX = (ONE <<< (B - 1)) - ONE;
   localparam logic signed [W-1:0] Q_MIN = ~Q_MAX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [KW-1:0]       k_q, k_d;
   logic                drain_q, drain_d;
   logic                issue_s, accept_s;
   logic                mode_q;
   logic [N_CH*B-1:0]   x_cap_q, y_cap_q;
   logic                s1_vld_q;
   logic [KW-1:0]       s1_idx_q;
   logic signed [B-1:0] s1_x_q;
   logic signed [W-1:0] s1_prod_q;
   logic [N_CH*B-1:0]   q_buf_q;
   logic [N_CH-1:0]     sat_buf_q;
   logic                busy_q, done_q, start_err_q;
   logic [N_CH*B-1:0]   p_q, q_q;
   logic [N_CH-1:0]     sat_q;

   logic signed [B-1:0] xk_s, yk_s, qk_s;
   logic signed [B+1:0] mul_a_s;
   logic signed [K+1:0] mul_c_s;
   logic signed [W-1:0] a_ext_s, c_ext_s, prod_s;
   logic signed [W-1:0] x_ext_s, bias_s, acc_s, shr_s;
   logic                satk_s;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      drain_d  = drain_q;
      issue_s  = 1'b0;
      accept_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               state_d  = ST_RUN;
               k_d      = {KW{1'b0}};
               accept_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            issue_s = 1'b1;
            if (k_q == KW'(N_CH - 1)) begin
               state_d = ST_DRAIN;
               k_d     = {KW{1'b0}};
               drain_d = 1'b0;
            end else begin
               k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
            end
         end
         ST_DRAIN: begin
            if (drain_q) begin
               state_d = ST_DONE;
               drain_d = 1'b0;
            end else begin
               drain_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Forward multiplies (x + 2y) by 1/sqrt3, inverse multiplies y by sqrt3/2; the -x/2 term is added in S2.
   always_comb begin
      xk_s = x_cap_q[k_q*B +: B];
      yk_s = y_cap_q[k_q*B +: B];
      if (mode_q) begin
         mul_a_s = {{2{yk_s[B-1]}}, yk_s};
         mul_c_s = C_INV;
      end else begin
         mul_a_s = {{2{xk_s[B-1]}}, xk_s} + {yk_s[B-1], yk_s, 1'b0};
         mul_c_s = C_FWD;
      end
      a_ext_s = {{(W-B-2){mul_a_s[B+1]}}, mul_a_s};
      c_ext_s = {{(W-K-2){mul_c_s[K+1]}}, mul_c_s};
      prod_s  = a_ext_s * c_ext_s;
   end

   always_comb begin
      x_ext_s = {{(W-B){s1_x_q[B-1]}}, s1_x_q};
      if (mode_q) begin
         bias_s = HALF - (x_ext_s <<< (K - 1));
      end else begin
         bias_s = HALF;
      end
      acc_s = s1_prod_q + bias_s;
      shr_s = acc_s >>> K;
      if (shr_s > Q_MAX) begin
         qk_s   = Q_MAX[B-1:0];
         satk_s = 1'b1;
      end else if (shr_s < Q_MIN) begin
         qk_s   = Q_MIN[B-1:0];
         satk_s = 1'b1;
      end else begin
         qk_s   = shr_s[B-1:0];
         satk_s = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         k_q     <= {KW{1'b0}};
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q  <= 1'b0;
         x_cap_q <= {(N_CH*B){1'b0}};
         y_cap_q <= {(N_CH*B){1'b0}};
      end else if (accept_s) begin
         mode_q  <= bus.i_mode;
         x_cap_q <= bus.i_x;
         y_cap_q <= bus.i_y;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_vld_q  <= 1'b0;
         s1_idx_q  <= {KW{1'b0}};
         s1_x_q    <= {B{1'b0}};
         s1_prod_q <= {W{1'b0}};
      end else begin
         s1_vld_q <= issue_s;
         if (issue_s) begin
            s1_idx_q  <= k_q;
            s1_x_q    <= xk_s;
            s1_prod_q <= prod_s;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         q_buf_q   <= {(N_CH*B){1'b0}};
         sat_buf_q <= {N_CH{1'b0}};
      end else if (s1_vld_q) begin
         q_buf_q[s1_idx_q*B +: B] <= qk_s;
         sat_buf_q[s1_idx_q]      <= satk_s;
      end
   end

   // Status flags follow the next state so they line up with the state they describe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
         p_q         <= {(N_CH*B){1'b0}};
         q_q         <= {(N_CH*B){1'b0}};
         sat_q       <= {N_CH{1'b0}};
      end else begin
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         start_err_q <= bus.i_start & busy_q;
         if (state_d == ST_DONE) begin
            p_q   <= x_cap_q;
            q_q   <= q_buf_q;
            sat_q <= sat_buf_q;
         end
      end
   end

   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_start_err = start_err_q;
   assign bus.o_p         = p_q;
   assign bus.o_q         = q_q;
   assign bus.o_sat       = sat_q;

endmodule

// File: tb/tb_jpl_foc_clarke_mc.sv
// Self-checking bench for jpl_foc_clarke_mc: directed vectors, handshake/reset timing, and randomized
// frames checked against an integer reference model of the Clarke equations.
module tb_jpl_foc_clarke_mc;
   localparam int B  = 12;
   localparam int N  = 2;
   localparam int BS = 4;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   jpl_foc_clarke_mc_if #(.B(B),  .N_CH(N))  bus_if ();
   jpl_foc_clarke_mc_if #(.B(BS), .N_CH(NS)) sw_if ();

   jpl_foc_clarke_mc #(.B(B),  .N_CH(N),  .K(15)) dut    (.i_clk(clk), .i_rst(rst), .bus(bus_if));
   jpl_foc_clarke_mc #(.B(BS), .N_CH(NS), .K(15)) dut_sw (.i_clk(clk), .i_rst(rst), .bus(sw_if));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   function automatic longint lane(input logic [63:0] v, input int k, input int bw);
      longint r;
      r = longint'((v >> (k * bw)) & ((64'd1 << bw) - 64'd1));
      if (r >= (longint'(1) << (bw - 1))) r -= (longint'(1) << bw);
      return r;
   endfunction

   // Reference: q = clip(floor((num + 2^14) / 2^15)) with num from the forward or inverse equation.
   task automatic model_frame(input bit mode, input logic [63:0] x, input logic [63:0] y,
                              input int bw, input int nch,
                              output logic [63:0] eq, output logic [7:0] es);
      longint xv, yv, n, v, hi, lo;
      eq = 64'd0;
      es = 8'd0;
      hi = (longint'(1) << (bw - 1)) - 1;
      lo = -hi - 1;
      for (int k = 0; k < nch; k++) begin
         xv = lane(x, k, bw);
         yv = lane(y, k, bw);
         if (!mode) n = (xv + 2 * yv) * 18919 + 16384;
         else       n = yv * 28378 - xv * 16384 + 16384;
         v = floor_div(n, 32768);
         if (v > hi) begin v = hi; es[k] = 1'b1; end
         if (v < lo) begin v = lo; es[k] = 1'b1; end
         eq |= (64'(v) & ((64'd1 << bw) - 64'd1)) << (k * bw);
      end
   endtask

   task automatic run_frame(input bit mode, input logic [23:0] x, input logic [23:0] y,
                            output int done_cyc, output int n_done, output logic [63:0] busy_map);
      bus_if.i_mode  = mode;
      bus_if.i_x     = x;
      bus_if.i_y     = y;
      bus_if.i_start = 1'b1;
      tick();
      bus_if.i_start = 1'b0;
      bus_if.i_mode  = 1'($urandom);
      bus_if.i_x     = 24'($urandom);
      bus_if.i_y     = 24'($urandom);
      done_cyc = -1;
      n_done   = 0;
      busy_map = 64'd0;
      for (int c = 1; c < 40; c++) begin
         busy_map[c] = bus_if.o_busy;
         if (bus_if.o_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c > done_cyc) break;
         tick();
      end
   endtask

   task automatic run_frame_sw(input bit mode, input logic [15:0] x, input logic [15:0] y,
                               output int done_cyc);
      sw_if.i_mode  = mode;
      sw_if.i_x     = x;
      sw_if.i_y     = y;
      sw_if.i_start = 1'b1;
      tick();
      sw_if.i_start = 1'b0;
      sw_if.i_x     = 16'($urandom);
      sw_if.i_y     = 16'($urandom);
      done_cyc = -1;
      for (int c = 1; c < 40; c++) begin
         if (sw_if.o_done && done_cyc < 0) done_cyc = c;
         if (done_cyc >= 0 && c > done_cyc) break;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({bus_if.o_busy, bus_if.o_done, bus_if.o_start_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000", {bus_if.o_busy, bus_if.o_done, bus_if.o_start_err});
      end
      n_tests++;
      if ({bus_if.o_p, bus_if.o_q, bus_if.o_sat} !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_data: got p=%h q=%h sat=%b want zeros", bus_if.o_p, bus_if.o_q, bus_if.o_sat);
      end
      n_tests++;
      if ({sw_if.o_busy, sw_if.o_done, sw_if.o_q, sw_if.o_sat} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_sweep_dut: got q=%h sat=%b want zeros", sw_if.o_q, sw_if.o_sat);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_forward();
      int dc, nd;
      logic [63:0] bm;
      run_frame(1'b0, {12'd1000, 12'd1000}, {12'hE0C, 12'h000}, dc, nd, bm);
      n_tests++;
      if (bus_if.o_q !== 24'h000241) begin
         n_fail++;
         $display("FAIL fwd_q: got %h want 000241", bus_if.o_q);
      end
      n_tests++;
      if (bus_if.o_p !== 24'h3E83E8 || bus_if.o_sat !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_p_sat: got p=%h sat=%b want 3e83e8/00", bus_if.o_p, bus_if.o_sat);
      end
      n_tests++;
      if (dc !== 5 || nd !== 1) begin
         n_fail++;
         $display("FAIL fwd_done_cycle: got cycle %0d count %0d want 5/1", dc, nd);
      end
      n_tests++;
      if (bm !== 64'h3E) begin
         n_fail++;
         $display("FAIL fwd_busy_cycles: got %h want 3e", bm);
      end
   endtask

   task automatic test_saturation();
      int dc, nd;
      logic [63:0] bm;
      run_frame(1'b0, {12'h800, 12'h7FF}, {12'h800, 12'h7FF}, dc, nd, bm);
      n_tests++;
      if (bus_if.o_q !== 24'h8007FF || bus_if.o_sat !== 2'b11) begin
         n_fail++;
         $display("FAIL sat_clip: got q=%h sat=%b want 8007ff/11", bus_if.o_q, bus_if.o_sat);
      end
      run_frame(1'b0, {12'd1000, 12'd1000}, {12'hE0C, 12'h000}, dc, nd, bm);
      n_tests++;
      if (bus_if.o_sat !== 2'b00 || bus_if.o_q !== 24'h000241) begin
         n_fail++;
         $display("FAIL sat_clear: got q=%h sat=%b want 000241/00", bus_if.o_q, bus_if.o_sat);
      end
   endtask

   task automatic test_inverse();
      int dc, nd;
      logic [63:0] bm;
      run_frame(1'b1, {12'd0, 12'd1000}, {12'd1000, 12'd0}, dc, nd, bm);
      n_tests++;
      if (bus_if.o_q !== 24'h362E0C) begin
         n_fail++;
         $display("FAIL inv_q: got %h want 362e0c", bus_if.o_q);
      end
      n_tests++;
      if (bus_if.o_p !== 24'h0003E8 || bus_if.o_sat !== 2'b00) begin
         n_fail++;
         $display("FAIL inv_p_sat: got p=%h sat=%b want 0003e8/00", bus_if.o_p, bus_if.o_sat);
      end
   endtask

   task automatic test_handshake();
      logic [31:0] done_map, err_map;
      logic [23:0] q6, q12;
      done_map = 32'd0;
      err_map  = 32'd0;
      q6       = 24'd0;
      q12      = 24'd0;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            done_map[c] = bus_if.o_done;
            err_map[c]  = bus_if.o_start_err;
         end
         if (c == 6)  q6  = bus_if.o_q;
         if (c == 12) q12 = bus_if.o_q;
         if (c == 0) begin
            bus_if.i_mode = 1'b1;
            bus_if.i_x    = {12'd0, 12'd1000};
            bus_if.i_y    = {12'd1000, 12'd0};
         end
         if (c == 3) begin
            bus_if.i_mode = 1'b0;
            bus_if.i_x    = {12'd1000, 12'd1000};
            bus_if.i_y    = {12'hE0C, 12'h000};
         end
         bus_if.i_start = (c == 0 || c == 3 || c == 5 || c == 6);
         tick();
      end
      bus_if.i_start = 1'b0;
      n_tests++;
      if (err_map !== 32'h50) begin
         n_fail++;
         $display("FAIL hs_start_err: got %h want 00000050", err_map);
      end
      n_tests++;
      if (done_map !== 32'h820) begin
         n_fail++;
         $display("FAIL hs_done: got %h want 00000820", done_map);
      end
      n_tests++;
      if (q6 !== 24'h362E0C || q12 !== 24'h000241) begin
         n_fail++;
         $display("FAIL hs_data: got q6=%h q12=%h want 362e0c/000241", q6, q12);
      end
   endtask

   task automatic test_input_hold();
      int dc, nd, extra;
      logic [63:0] bm, eq;
      logic [7:0]  es;
      logic [23:0] x, y;
      x = 24'($urandom);
      y = 24'($urandom);
      model_frame(1'b1, {40'd0, x}, {40'd0, y}, B, N, eq, es);
      run_frame(1'b1, x, y, dc, nd, bm);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         bus_if.i_x    = 24'($urandom);
         bus_if.i_y    = 24'($urandom);
         bus_if.i_mode = 1'($urandom);
         tick();
         if (bus_if.o_done) extra++;
      end
      n_tests++;
      if (bus_if.o_q !== eq[23:0] || bus_if.o_p !== x || extra !== 0) begin
         n_fail++;
         $display("FAIL hold: got q=%h p=%h extra_done=%0d want %h/%h/0", bus_if.o_q, bus_if.o_p, extra, eq[23:0], x);
      end
   endtask

   task automatic test_reset_midframe();
      int dc, nd, stray;
      logic [63:0] bm;
      bus_if.i_mode  = 1'b0;
      bus_if.i_x     = 24'h123456;
      bus_if.i_y     = 24'h654321;
      bus_if.i_start = 1'b1;
      tick();
      bus_if.i_start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus_if.o_busy, bus_if.o_done, bus_if.o_start_err, bus_if.o_p, bus_if.o_q, bus_if.o_sat} !== 53'd0) begin
         n_fail++;
         $display("FAIL rst_mid: got busy=%b done=%b p=%h q=%h sat=%b want zeros",
                  bus_if.o_busy, bus_if.o_done, bus_if.o_p, bus_if.o_q, bus_if.o_sat);
      end
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus_if.o_done || bus_if.o_busy) stray++;
      end
      n_tests++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL rst_abort: got %0d busy/done cycles want 0", stray);
      end
      run_frame(1'b0, {12'd1000, 12'd1000}, {12'hE0C, 12'h000}, dc, nd, bm);
      n_tests++;
      if (dc !== 5 || bus_if.o_q !== 24'h000241) begin
         n_fail++;
         $display("FAIL rst_recover: got cycle %0d q=%h want 5/000241", dc, bus_if.o_q);
      end
   endtask

   task automatic test_back_to_back_random();
      int dc, nd;
      logic [63:0] bm, eq;
      logic [7:0]  es;
      logic [23:0] x, y;
      bit          m;
      for (int i = 0; i < 24; i++) begin
         m = 1'($urandom);
         x = 24'($urandom);
         y = 24'($urandom);
         model_frame(m, {40'd0, x}, {40'd0, y}, B, N, eq, es);
         run_frame(m, x, y, dc, nd, bm);
         n_tests++;
         if (bus_if.o_q !== eq[23:0] || bus_if.o_sat !== es[1:0] || bus_if.o_p !== x) begin
            n_fail++;
            $display("FAIL rand_frame %0d: got q=%h sat=%b p=%h want %h/%b/%h",
                     i, bus_if.o_q, bus_if.o_sat, bus_if.o_p, eq[23:0], es[1:0], x);
         end
         n_tests++;
         if (dc !== 5 || nd !== 1 || bm !== 64'h3E) begin
            n_fail++;
            $display("FAIL rand_timing %0d: got cycle %0d count %0d busy %h want 5/1/3e", i, dc, nd, bm);
         end
      end
   endtask

   task automatic test_sweep();
      int dc;
      logic [63:0] eq;
      logic [7:0]  es;
      logic [15:0] xs, ys;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) begin
            xs = 16'($urandom);
            for (int k = 0; k < NS; k++) ys[k*BS +: BS] = 4'((i + 5 * k) % 16);
            model_frame(m[0], {48'd0, xs}, {48'd0, ys}, BS, NS, eq, es);
            run_frame_sw(m[0], xs, ys, dc);
            n_tests++;
            if (sw_if.o_q !== eq[15:0] || sw_if.o_sat !== es[3:0] || sw_if.o_p !== xs || dc !== 7) begin
               n_fail++;
               $display("FAIL sweep m=%0d i=%0d: got q=%h sat=%b p=%h cyc=%0d want %h/%b/%h/7",
                        m, i, sw_if.o_q, sw_if.o_sat, sw_if.o_p, dc, eq[15:0], es[3:0], xs);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst            = 1'b1;
      bus_if.i_start = 1'b0;
      bus_if.i_mode  = 1'b0;
      bus_if.i_x     = 24'd0;
      bus_if.i_y     = 24'd0;
      sw_if.i_start  = 1'b0;
      sw_if.i_mode   = 1'b0;
      sw_if.i_x      = 16'd0;
      sw_if.i_y      = 16'd0;
      test_reset();
      test_forward();
      test_saturation();
      test_inverse();
      test_handshake();
      test_input_hold();
      test_reset_midframe();
      test_back_to_back_random();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/jpl_foc_clarke_mc.md
# jpl_foc_clarke_mc

Multi-channel Clarke / inverse-Clarke transform for the FOC datapath, succeeding the single-channel 3-phase→αβ block. One start pulse captures N_CH channel pairs. The block processes them through a single shared multiplier pipeline, with rounding and saturation to B bits. It then issues one done pulse with all results valid. It sits between the ADC phase-current front end (forward mode) and the PWM/SVM stage (inverse mode), so one instance can serve several motors.

## Interface
- B, default 12: signed sample width of every input and output lane.
- N_CH, default 2: channel count, ≥1.
- K, default 15: fractional bits of the internal constants, ≥2.
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle request pulse; sampled only when o_busy=0.
- i_mode  in  1  0 = forward Clarke, 1 = inverse Clarke; captured with i_start.
- i_x  in  N_CH*B  packed signed lane x[k] = bits [k*B +: B]; ia (forward) or alpha (inverse).
- i_y  in  N_CH*B  packed signed lane y[k]; ib (forward) or beta (inverse).
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse, results valid.
- o_p  out  N_CH*B  packed result lane p[k]: alpha (forward) or ia (inverse).
- o_q  out  N_CH*B  packed result lane q[k]: beta (forward) or ib (inverse).
- o_sat  out  N_CH  per-channel flag: q[k] was clipped during the last frame.
- o_start_err  out  1  one-cycle pulse: i_start was seen while o_busy=1 and was ignored.

## Operation
- Constants: C_FWD = round(2^K/√3), which is 18919 at K=15. C_INV = round(2^K·√3/2), which is 28378 at K=15.
- Forward mode: p = x. q = sat_B((( x + 2y )·C_FWD + 2^(K-1)) >>> K).
- Inverse mode: p = x. q = sat_B((y·C_INV − x·2^(K-1) + 2^(K-1)) >>> K), which equals −x/2 + (√3/2)·y.
- Rounding is round-half-up with an arithmetic shift, so the shift is floor-based.
- Intermediates are wide enough that overflow is impossible. Forward uses B+2 bits for the sum and B+K+3 bits for the product.
- sat_B clips to [−2^(B-1), 2^(B-1)−1] and sets o_sat[k] when it clips.
- p is never modified or saturated.
- On the i_start edge the block registers all of i_x, i_y and i_mode. Inputs may change freely afterwards.
- One shared multiplier, two-stage pipeline:
  - S1 registers the product for channel index k.
  - S2 registers the rounded, saturated lane k into the result buffer.
- FSM states:
  - IDLE: o_busy=0. i_start goes to RUN with k=0.
  - RUN: issue channel k into S1 each cycle; k increments. After issuing k=N_CH−1, go to DRAIN.
  - DRAIN: 2 cycles to empty S1/S2, then go to DONE.
  - DONE: 1 cycle. o_p, o_q and o_sat update from the result buffer, and o_done=1. Then go to IDLE.
- o_p, o_q and o_sat hold their values between o_done pulses. o_sat is replaced every frame, not accumulated.

## Timing
- Reset values: state IDLE, k=0, o_busy=0, o_done=0, o_start_err=0, o_p=0, o_q=0, o_sat=0, pipeline valid bits 0.
- Latency: call the cycle where i_start is sampled high cycle 0. o_busy=1 in cycles 1 … N_CH+3. o_done=1 in cycle N_CH+3 only.
- Throughput: the earliest next accepted start is in cycle N_CH+4, giving one frame per N_CH+4 cycles.
- Start while o_busy=1, including the DONE cycle: the start is ignored, the frame is unaffected, and o_start_err pulses the next cycle.
- i_rst while busy: the block returns to reset values on the next edge. No o_done is issued for the aborted frame.
- i_rst wins over a simultaneous i_start.
- N_CH=1: RUN lasts one cycle, and latency is 4.

## Test plan
- Forward, B=12, N_CH=2, K=15.
  - Stimulus: x={1000, 1000}, y={0, −500}.
  - Required: o_q={577, 0}, o_p={1000, 1000}, o_sat=00. o_done in cycle 5, o_busy for cycles 1–5.
- Forward saturation.
  - Stimulus: x={2047, −2048}, y={2047, −2048}.
  - Required: o_q={2047, −2048}, o_sat=11.
  - Then a non-clipping frame: o_sat returns to 00.
- Inverse.
  - Stimulus: x={1000, 0}, y={0, 1000}.
  - Required: o_q={−500, 866}, o_p={1000, 0}.
- Handshake.
  - Stimulus: i_start pulses in cycles 0, 3 and 5.
  - Required: the cycle-3 and cycle-5 starts are ignored, with o_start_err in cycles 4 and 6. A single o_done in cycle 5. A start in cycle 6 is accepted, with o_done in cycle 11.
  - Stimulus: after the frame completes, inputs are changed in cycle 1.
  - Required: results unchanged.
- Reset mid-frame.
  - Stimulus: i_rst=1 in cycle 2.
  - Required: all outputs 0 next cycle and no o_done. A subsequent start completes normally with latency 5.
- Sweep.
  - Stimulus: N_CH=4, B=4; i_y ramps through all 16 codes per lane.
  - Required: every o_q matches a bit-exact reference model.
